// File: rtl/irda_pkg.sv
// Shared definitions for the IrDA/UART transmitter: FSM state encoding,
// IrDA pulse-width computation and parameter legality checking.
package irda_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_HOLD   = 3'd5
    } tx_state_t;

    // IrDA SIR pulse is nominally 3/16 of a bit period, rounded, never below one clock.
    function automatic int calc_pw(input int clks_per_bit);
        int pw;
        pw = (3 * clks_per_bit + 8) / 16;
        return (pw < 1) ? 1 : pw;
    endfunction

    function automatic bit params_legal(input int data_w, input int clks_per_bit,
                                        input int stop_bits);
        return (data_w >= 5) && (data_w <= 9) && (clks_per_bit >= 4) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/irda_uart_tx_if.sv
// Host-side handshake plus line outputs of the IrDA/UART transmitter.
interface irda_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              send;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              txd;
    logic              ir_out;

    modport master (output send, data, input busy, done, txd, ir_out);
    modport slave  (input send, data, output busy, done, txd, ir_out);
endinterface

// File: rtl/irda_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the last count, and
// can be re-aligned to a fresh bit boundary with clear.
module irda_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    output logic                            tick,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/irda_uart_tx.sv
// IrDA/UART transmitter: frame FSM, shift register, bit counter, parity and
// the optional SIR pulse encoder, all with registered outputs.
module irda_uart_tx
    import irda_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int IRDA_MODE    = 1
) (
    input  logic           clk,
    input  logic           reset,
    irda_uart_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int PW    = calc_pw(CLKS_PER_BIT);

    if (!params_legal(DATA_W, CLKS_PER_BIT, STOP_BITS)) begin : g_param_check
        $error("irda_uart_tx: illegal DATA_W, CLKS_PER_BIT or STOP_BITS");
    end

    tx_state_t         state;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic              parity_bit;
    logic              txd_q;
    logic              ir_q;
    logic              busy_q;
    logic              done_q;

    logic              baud_clear;
    logic              baud_tick;
    logic [CNT_W-1:0]  baud_cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    assign baud_clear = (state == ST_IDLE) && bus.send;
    // Baud count that will be visible alongside the next registered line value.
    assign cnt_nxt    = (baud_clear || baud_tick) ? '0 : baud_cnt + 1'b1;

    irda_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (baud_tick),
        .count (baud_cnt)
    );

    function automatic logic ir_pulse(input logic line_bit, input logic [CNT_W-1:0] cnt);
        return (IRDA_MODE != 0) && !line_bit && (int'(cnt) < PW);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            txd_q      <= 1'b1;
            ir_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Line level holds unless a transition below changes it.
            ir_q <= ir_pulse(txd_q, cnt_nxt);
            unique case (state)
                ST_IDLE: begin
                    if (bus.send) begin
                        shift_reg  <= bus.data;
                        parity_bit <= (^bus.data) ^ (PARITY_ODD != 0);
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        txd_q      <= 1'b0;
                        ir_q       <= ir_pulse(1'b0, cnt_nxt);
                        busy_q     <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        txd_q <= shift_reg[0];
                        ir_q  <= ir_pulse(shift_reg[0], cnt_nxt);
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            if (PARITY_EN != 0) begin
                                txd_q <= parity_bit;
                                ir_q  <= ir_pulse(parity_bit, cnt_nxt);
                                state <= ST_PARITY;
                            end else begin
                                txd_q <= 1'b1;
                                ir_q  <= 1'b0;
                                state <= ST_STOP;
                            end
                        end else begin
                            txd_q <= shift_reg[1];
                            ir_q  <= ir_pulse(shift_reg[1], cnt_nxt);
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        txd_q <= 1'b1;
                        ir_q  <= 1'b0;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_HOLD;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // A new frame needs send to drop first; no retrigger from a held level.
                    if (!bus.send) begin
                        done_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.txd    = txd_q;
    assign bus.ir_out = ir_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
